// File: rtl/rob_rename_unit.sv
// Rename table plus circular reorder buffer: allocates tags at dispatch, renames sources,
// captures CDB results and retires entries to the register file in program order.
module rob_rename_unit #(
   parameter  int NUM_REGS  = 32,
   parameter  int ROB_DEPTH = 8,
   parameter  int DATA_W    = 32,
   localparam int RW        = $clog2(NUM_REGS),
   localparam int TW        = $clog2(ROB_DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              disp_valid_i,
   output logic              disp_ready_o,
   input  logic [RW-1:0]     disp_rd_i,
   input  logic [RW-1:0]     disp_rs1_i,
   input  logic [RW-1:0]     disp_rs2_i,
   input  logic              disp_rd_we_i,
   output logic [TW-1:0]     disp_tag_o,
   output logic              rs1_busy_o,
   output logic [TW-1:0]     rs1_tag_o,
   output logic              rs1_fwd_o,
   output logic [DATA_W-1:0] rs1_value_o,
   output logic              rs2_busy_o,
   output logic [TW-1:0]     rs2_tag_o,
   output logic              rs2_fwd_o,
   output logic [DATA_W-1:0] rs2_value_o,
   input  logic              cdb_valid_i,
   input  logic [TW-1:0]     cdb_tag_i,
   input  logic [DATA_W-1:0] cdb_value_i,
   output logic              commit_valid_o,
   output logic              commit_we_o,
   output logic [RW-1:0]     commit_rd_o,
   output logic [DATA_W-1:0] commit_value_o,
   output logic [TW-1:0]     commit_tag_o,
   input  logic              flush_i,
   output logic [TW:0]       rob_count_o
);

   localparam logic [TW:0]   FULL_CNT = (TW+1)'(ROB_DEPTH);
   localparam logic [TW:0]   CNT_ONE  = (TW+1)'(1);
   localparam logic [TW-1:0] PTR_ONE  = TW'(1);

   logic [TW-1:0]     head_q, head_d;
   logic [TW-1:0]     tail_q, tail_d;
   logic [TW:0]       count_q, count_d;

   logic              rob_valid_q [ROB_DEPTH];
   logic              rob_done_q  [ROB_DEPTH];
   logic              rob_we_q    [ROB_DEPTH];
   logic [RW-1:0]     rob_rd_q    [ROB_DEPTH];
   logic [DATA_W-1:0] rob_value_q [ROB_DEPTH];

   logic              rat_busy_q  [NUM_REGS];
   logic [TW-1:0]     rat_tag_q   [NUM_REGS];

   logic              dispatch;
   logic              commit;
   logic              cdb_write;
   logic              disp_we;

   logic [RW-1:0]     src_idx   [2];
   logic              src_busy  [2];
   logic [TW-1:0]     src_tag   [2];
   logic              src_cdb   [2];
   logic              src_fwd   [2];
   logic [DATA_W-1:0] src_value [2];

   // Ready depends only on registered count and flush, never on disp_valid.
   assign disp_ready_o = (count_q != FULL_CNT) && !flush_i;
   assign dispatch     = disp_valid_i && disp_ready_o;
   assign disp_we      = disp_rd_we_i && (disp_rd_i != '0);
   assign disp_tag_o   = tail_q;

   assign commit       = rob_valid_q[head_q] && rob_done_q[head_q] && !flush_i;
   assign cdb_write    = cdb_valid_i && rob_valid_q[cdb_tag_i] && !flush_i;

   assign commit_valid_o = commit;
   assign commit_we_o    = commit && rob_we_q[head_q];
   assign commit_rd_o    = rob_rd_q[head_q];
   assign commit_value_o = rob_value_q[head_q];
   assign commit_tag_o   = head_q;
   assign rob_count_o    = count_q;

   assign src_idx[0] = disp_rs1_i;
   assign src_idx[1] = disp_rs2_i;

   // Lookup reads the pre-dispatch RAT so rs==rd sees the older producer.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         src_busy[n]  = 1'b0;
         src_tag[n]   = '0;
         src_cdb[n]   = 1'b0;
         src_fwd[n]   = 1'b0;
         src_value[n] = '0;
         src_busy[n]  = (src_idx[n] != '0) && rat_busy_q[src_idx[n]];
         if (src_busy[n]) begin
            src_tag[n] = rat_tag_q[src_idx[n]];
            src_cdb[n] = cdb_valid_i && (cdb_tag_i == src_tag[n]);
            src_fwd[n] = rob_done_q[src_tag[n]] || src_cdb[n];
            if (src_cdb[n])
               src_value[n] = cdb_value_i;
            else if (src_fwd[n])
               src_value[n] = rob_value_q[src_tag[n]];
         end
      end
   end

   assign rs1_busy_o  = src_busy[0];
   assign rs1_tag_o   = src_tag[0];
   assign rs1_fwd_o   = src_fwd[0];
   assign rs1_value_o = src_value[0];
   assign rs2_busy_o  = src_busy[1];
   assign rs2_tag_o   = src_tag[1];
   assign rs2_fwd_o   = src_fwd[1];
   assign rs2_value_o = src_value[1];

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (commit)
            head_d = head_q + PTR_ONE;
         if (dispatch)
            tail_d = tail_q + PTR_ONE;
         if (dispatch && !commit)
            count_d = count_q + CNT_ONE;
         else if (!dispatch && commit)
            count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            rob_valid_q[i] <= 1'b0;
            rob_done_q[i]  <= 1'b0;
            rob_we_q[i]    <= 1'b0;
            rob_rd_q[i]    <= '0;
            rob_value_q[i] <= '0;
         end
      end else if (flush_i) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            rob_valid_q[i] <= 1'b0;
            rob_done_q[i]  <= 1'b0;
         end
      end else begin
         if (cdb_write) begin
            rob_done_q[cdb_tag_i]  <= 1'b1;
            rob_value_q[cdb_tag_i] <= cdb_value_i;
         end
         if (commit) begin
            rob_valid_q[head_q] <= 1'b0;
            rob_done_q[head_q]  <= 1'b0;
         end
         // Tail never aliases head or a CDB-written entry when dispatch fires.
         if (dispatch) begin
            rob_valid_q[tail_q] <= 1'b1;
            rob_done_q[tail_q]  <= 1'b0;
            rob_we_q[tail_q]    <= disp_we;
            rob_rd_q[tail_q]    <= disp_rd_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            rat_busy_q[r] <= 1'b0;
            rat_tag_q[r]  <= '0;
         end
      end else if (flush_i) begin
         for (int r = 0; r < NUM_REGS; r++)
            rat_busy_q[r] <= 1'b0;
      end else begin
         // Only the youngest producer may release the mapping; a same-cycle dispatch overrides.
         if (commit && rob_we_q[head_q] && (rat_tag_q[rob_rd_q[head_q]] == head_q))
            rat_busy_q[rob_rd_q[head_q]] <= 1'b0;
         if (dispatch && disp_we) begin
            rat_busy_q[disp_rd_i] <= 1'b1;
            rat_tag_q[disp_rd_i]  <= tail_q;
         end
      end
   end

endmodule

// File: tb/tb_rob_rename_unit.sv
// Directed bench for rob_rename_unit with default parameters (32 regs, 8 entries, 32-bit data).
module tb_rob_rename_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        disp_valid, disp_ready, disp_rd_we;
   logic [4:0]  disp_rd, disp_rs1, disp_rs2;
   logic [2:0]  disp_tag;
   logic        rs1_busy, rs1_fwd, rs2_busy, rs2_fwd;
   logic [2:0]  rs1_tag, rs2_tag;
   logic [31:0] rs1_value, rs2_value;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        commit_valid, commit_we;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value;
   logic [2:0]  commit_tag;
   logic        flush;
   logic [3:0]  rob_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rob_rename_unit dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
      .disp_rd_i(disp_rd), .disp_rs1_i(disp_rs1), .disp_rs2_i(disp_rs2),
      .disp_rd_we_i(disp_rd_we), .disp_tag_o(disp_tag),
      .rs1_busy_o(rs1_busy), .rs1_tag_o(rs1_tag), .rs1_fwd_o(rs1_fwd), .rs1_value_o(rs1_value),
      .rs2_busy_o(rs2_busy), .rs2_tag_o(rs2_tag), .rs2_fwd_o(rs2_fwd), .rs2_value_o(rs2_value),
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
      .commit_valid_o(commit_valid), .commit_we_o(commit_we), .commit_rd_o(commit_rd),
      .commit_value_o(commit_value), .commit_tag_o(commit_tag),
      .flush_i(flush), .rob_count_o(rob_count)
   );

   task automatic idle();
      disp_valid = 0; disp_rd = 0; disp_rs1 = 0; disp_rs2 = 0; disp_rd_we = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0; flush = 0;
   endtask

   // Advance to just after the next rising edge; inputs then change away from the edge.
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_disp(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      disp_valid = 1; disp_rd = rd; disp_rs1 = rs1; disp_rs2 = rs2; disp_rd_we = 1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      step();
      rst_n = 1;
      step();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      #3;
      tests++; if (disp_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%0b exp=1", disp_ready); end
      tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL reset_commit got=%0b exp=0", commit_valid); end
      tests++; if (rob_count !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", rob_count); end
      tests++; if ({rs1_busy, rs1_fwd, rs1_tag, rs1_value, rs2_busy, rs2_fwd, rs2_tag, rs2_value} !== '0) begin
         fails++; $display("FAIL reset_rs got=%0b/%0b/%0h exp=0", rs1_busy, rs2_busy, rs1_value); end
      step();
      rst_n = 1;
      step();
   endtask

   task automatic test_dependency();
      do_reset();
      set_disp(5'd3, 5'd1, 5'd2);
      #1;
      tests++; if (disp_tag !== 3'd0) begin fails++; $display("FAIL dep_tag0 got=%0d exp=0", disp_tag); end
      tests++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL dep_rs1_idle got=%0b exp=0", rs1_busy); end
      step();
      set_disp(5'd4, 5'd3, 5'd0);
      #1;
      tests++; if (disp_tag !== 3'd1) begin fails++; $display("FAIL dep_tag1 got=%0d exp=1", disp_tag); end
      tests++; if ({rs1_busy, rs1_tag, rs1_fwd} !== {1'b1, 3'd0, 1'b0}) begin
         fails++; $display("FAIL dep_rs1 got=busy%0b tag%0d fwd%0b exp=busy1 tag0 fwd0", rs1_busy, rs1_tag, rs1_fwd); end
      tests++; if (rs2_busy !== 1'b0) begin fails++; $display("FAIL dep_r0_busy got=%0b exp=0", rs2_busy); end
      step();
      // Forward from CDB while dispatching r5 <= r3.
      set_disp(5'd5, 5'd3, 5'd4);
      cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h0000_00AA;
      #1;
      tests++; if ({rs1_fwd, rs1_value} !== {1'b1, 32'hAA}) begin
         fails++; $display("FAIL fwd_rs1 got=fwd%0b val%0h exp=fwd1 valaa", rs1_fwd, rs1_value); end
      tests++; if ({rs2_busy, rs2_tag, rs2_fwd} !== {1'b1, 3'd1, 1'b0}) begin
         fails++; $display("FAIL fwd_rs2 got=busy%0b tag%0d fwd%0b exp=busy1 tag1 fwd0", rs2_busy, rs2_tag, rs2_fwd); end
      tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL fwd_no_early_commit got=%0b exp=0", commit_valid); end
      step();
      idle();
      disp_rs1 = 5'd3;
      #1;
      tests++; if ({commit_valid, commit_we, commit_rd, commit_value, commit_tag} !== {1'b1, 1'b1, 5'd3, 32'hAA, 3'd0}) begin
         fails++; $display("FAIL commit0 got=v%0b we%0b rd%0d val%0h tag%0d exp=v1 we1 rd3 valaa tag0",
                           commit_valid, commit_we, commit_rd, commit_value, commit_tag); end
      tests++; if ({rs1_fwd, rs1_value} !== {1'b1, 32'hAA}) begin
         fails++; $display("FAIL fwd_stored got=fwd%0b val%0h exp=fwd1 valaa", rs1_fwd, rs1_value); end
      tests++; if (rob_count !== 4'd3) begin fails++; $display("FAIL count3 got=%0d exp=3", rob_count); end
      step();
      tests++; if ({rs1_busy, rob_count} !== {1'b0, 4'd2}) begin
         fails++; $display("FAIL after_commit got=busy%0b cnt%0d exp=busy0 cnt2", rs1_busy, rob_count); end
   endtask

   task automatic test_out_of_order();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_disp(5'(i + 1), 5'd0, 5'd0);
         step();
      end
      idle();
      cdb_valid = 1; cdb_tag = 3'd2; cdb_value = 32'h12;
      step();
      cdb_tag = 3'd1; cdb_value = 32'h11;
      #1;
      tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL ooo_hold_a got=%0b exp=0", commit_valid); end
      step();
      cdb_valid = 0;
      #1;
      tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL ooo_hold_b got=%0b exp=0", commit_valid); end
      step();
      cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h10;
      step();
      cdb_valid = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if ({commit_valid, commit_tag, commit_rd, commit_value, rob_count} !==
                      {1'b1, 3'(i), 5'(i + 1), 32'(32'h10 + i), 4'(3 - i)}) begin
            fails++; $display("FAIL ooo_commit%0d got=v%0b tag%0d rd%0d val%0h cnt%0d exp=v1 tag%0d rd%0d val%0h cnt%0d",
                              i, commit_valid, commit_tag, commit_rd, commit_value, rob_count,
                              i, i + 1, 32'h10 + i, 3 - i); end
         step();
      end
      #1;
      tests++; if ({commit_valid, rob_count} !== {1'b0, 4'd0}) begin
         fails++; $display("FAIL ooo_empty got=v%0b cnt%0d exp=v0 cnt0", commit_valid, rob_count); end
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_disp(5'(i + 1), 5'd0, 5'd0);
         step();
      end
      set_disp(5'd9, 5'd0, 5'd0);
      #1;
      tests++; if ({disp_ready, rob_count} !== {1'b0, 4'd8}) begin
         fails++; $display("FAIL full got=rdy%0b cnt%0d exp=rdy0 cnt8", disp_ready, rob_count); end
      cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h55;
      step();
      cdb_valid = 0;
      #1;
      tests++; if ({commit_valid, disp_ready} !== {1'b1, 1'b0}) begin
         fails++; $display("FAIL full_commit got=v%0b rdy%0b exp=v1 rdy0", commit_valid, disp_ready); end
      step();
      #1;
      tests++; if ({disp_ready, disp_tag, rob_count} !== {1'b1, 3'd0, 4'd7}) begin
         fails++; $display("FAIL wrap got=rdy%0b tag%0d cnt%0d exp=rdy1 tag0 cnt7", disp_ready, disp_tag, rob_count); end
      step();
      idle();
      #1;
      tests++; if (rob_count !== 4'd8) begin fails++; $display("FAIL refill got=%0d exp=8", rob_count); end
   endtask

   task automatic test_rat_retain();
      do_reset();
      set_disp(5'd7, 5'd0, 5'd0);
      step();
      set_disp(5'd7, 5'd7, 5'd0);
      #1;
      tests++; if ({rs1_busy, rs1_tag} !== {1'b1, 3'd0}) begin
         fails++; $display("FAIL rs_eq_rd got=busy%0b tag%0d exp=busy1 tag0", rs1_busy, rs1_tag); end
      step();
      idle();
      cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h70;
      step();
      cdb_valid = 0;
      step();
      disp_rs1 = 5'd7;
      #1;
      tests++; if ({rs1_busy, rs1_tag, rs1_fwd} !== {1'b1, 3'd1, 1'b0}) begin
         fails++; $display("FAIL rat_keep got=busy%0b tag%0d fwd%0b exp=busy1 tag1 fwd0", rs1_busy, rs1_tag, rs1_fwd); end
      cdb_valid = 1; cdb_tag = 3'd1; cdb_value = 32'h71;
      step();
      cdb_valid = 0;
      set_disp(5'd7, 5'd7, 5'd0);
      #1;
      tests++; if ({commit_valid, commit_tag, disp_tag, rs1_fwd, rs1_value} !== {1'b1, 3'd1, 3'd2, 1'b1, 32'h71}) begin
         fails++; $display("FAIL rat_race got=v%0b ctag%0d dtag%0d fwd%0b val%0h exp=v1 ctag1 dtag2 fwd1 val71",
                           commit_valid, commit_tag, disp_tag, rs1_fwd, rs1_value); end
      step();
      idle();
      disp_rs1 = 5'd7;
      #1;
      tests++; if ({rs1_busy, rs1_tag} !== {1'b1, 3'd2}) begin
         fails++; $display("FAIL rat_new got=busy%0b tag%0d exp=busy1 tag2", rs1_busy, rs1_tag); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_disp(5'(i + 1), 5'd0, 5'd0);
         step();
      end
      set_disp(5'd6, 5'd0, 5'd0);
      cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h99;
      flush = 1;
      #1;
      tests++; if ({disp_ready, commit_valid} !== 2'b00) begin
         fails++; $display("FAIL flush_same got=rdy%0b v%0b exp=rdy0 v0", disp_ready, commit_valid); end
      step();
      idle();
      disp_rs1 = 5'd1; disp_rs2 = 5'd5;
      #1;
      tests++; if ({rob_count, rs1_busy, rs2_busy, commit_valid, disp_tag} !== {4'd0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
         fails++; $display("FAIL flush_next got=cnt%0d b%0b%0b v%0b tag%0d exp=cnt0 b00 v0 tag0",
                           rob_count, rs1_busy, rs2_busy, commit_valid, disp_tag); end
      cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h98;
      step();
      cdb_valid = 0;
      #1;
      tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL cdb_invalid got=%0b exp=0", commit_valid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_disp(5'd1, 5'd0, 5'd0);
      step();
      set_disp(5'd2, 5'd1, 5'd0);
      step();
      idle();
      disp_rs1 = 5'd1;
      #1;
      tests++; if ({rs1_busy, rob_count} !== {1'b1, 4'd2}) begin
         fails++; $display("FAIL pre_arst got=busy%0b cnt%0d exp=busy1 cnt2", rs1_busy, rob_count); end
      rst_n = 0;
      #1;
      tests++; if ({rs1_busy, rob_count, disp_ready} !== {1'b0, 4'd0, 1'b1}) begin
         fails++; $display("FAIL arst got=busy%0b cnt%0d rdy%0b exp=busy0 cnt0 rdy1", rs1_busy, rob_count, disp_ready); end
      step();
      rst_n = 1;
      step();
   endtask

   initial begin
      idle();
      rst_n = 1;
      test_reset();
      test_dependency();
      test_out_of_order();
      test_full_wrap();
      test_rat_retain();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rob_rename_unit.md
Name: rob_rename_unit

Overview:
- Parametrised rename table plus circular reorder buffer (ROB) for the Tomasulo core.
- Sits between decode and the reservation stations.
- At dispatch it allocates a ROB tag for the destination and renames the sources. For each source it tells the reservation station whether the register-file value is valid, or which tag to wait on, or it forwards a completed ROB value.
- Captures common-data-bus (CDB) results and retires entries in program order to the register file.

Parameters:
- NUM_REGS, 32, architectural register count; index width RW = clog2(NUM_REGS).
- ROB_DEPTH, 8, ROB entries; must be a power of two, at least 2. Tag width TW = clog2(ROB_DEPTH).
- DATA_W, 32, operand/result width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- disp_valid  in  1  decode presents an instruction
- disp_ready  out  1  ROB can accept an instruction
- disp_rd / disp_rs1 / disp_rs2  in  RW each  destination and source register indices
- disp_rd_we  in  1  instruction writes rd
- disp_tag  out  TW  ROB tag allocated to this instruction
- rsN_busy  out  1  (N=1,2) source is renamed; register-file value is stale
- rsN_tag  out  TW  producer tag when rsN_busy
- rsN_fwd  out  1  producer has already completed; rsN_value is valid
- rsN_value  out  DATA_W  forwarded producer result
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TW  tag of the result
- cdb_value  in  DATA_W  result value
- commit_valid  out  1  one entry retires this cycle
- commit_we  out  1  retired entry writes the register file
- commit_rd  out  RW  register to write
- commit_value  out  DATA_W  value to write
- commit_tag  out  TW  tag of the retiring entry
- flush  in  1  discard all in-flight state
- rob_count  out  TW+1  occupied entries

Behaviour:
- Reset (async, rst_n=0):
  - head=tail=0, count=0.
  - All ROB valid/done bits 0; all rename-table busy bits 0.
  - Outputs: disp_ready=1, commit_valid=0, rob_count=0, all rsN_* = 0.
- ROB entry state: valid, done, rd, we, value. Rename-table entry: busy, tag.
- disp_ready = (count != ROB_DEPTH) && !flush. It does not depend on a same-cycle commit, so a full ROB stalls for one cycle even if the head retires.
- Dispatch fires on disp_valid && disp_ready:
  - disp_tag = tail (combinational).
  - Entry[tail] becomes {valid=1, done=0, rd, we = disp_rd_we && disp_rd!=0}.
  - tail increments modulo ROB_DEPTH.
  - If we, then RAT[rd] <= {busy=1, tag=tail}.
- Source lookup (combinational):
  - Uses the RAT state before this cycle's dispatch update, so rs==rd reads the older producer.
  - Register 0 is never busy.
  - rsN_busy = RAT[rsN].busy.
  - rsN_fwd = busy && (entry[tag].done || (cdb_valid && cdb_tag==tag)).
  - rsN_value: CDB value has priority over the stored ROB value.
- CDB capture:
  - On cdb_valid with entry[cdb_tag].valid, set done=1 and latch the value. Visible to commit on the next cycle.
  - A broadcast to an invalid entry is ignored.
- Commit (combinational on registered state):
  - commit_valid = entry[head].valid && entry[head].done && !flush.
  - When commit_valid: head increments and the entry is cleared.
  - RAT[rd].busy is cleared only if RAT[rd].tag==head, and not when the same cycle's dispatch rewrites the same rd (dispatch wins).
  - Minimum latency: CDB at cycle n -> commit_valid at cycle n+1.
- Count update: count += dispatch − commit. Simultaneous dispatch and commit leaves count unchanged. Pointers wrap ROB_DEPTH-1 -> 0.
- Flush has top priority:
  - Next cycle: head=tail=0, count=0, all valid/done/busy cleared.
  - Same cycle: dispatch, CDB and commit are suppressed.
- At most one dispatch, one CDB write and one commit per cycle. No combinational path from disp_valid to disp_ready.

Test Plan:
- Reset then dispatch r3<=..., r4<=r3: first disp_tag=0. Second sees rs1_busy=1, rs1_tag=0, rs1_fwd=0, and gets disp_tag=1.
- CDB tag0=0x0000_00AA in the same cycle as dispatching r5<=r3: rs1_fwd=1, rs1_value=0xAA. Next cycle commit_valid=1, commit_rd=3, commit_value=0xAA, commit_we=1.
- Out-of-order completion: dispatch tags 0,1,2; CDB tag2 then tag1. No commit until tag0 completes, then commits occur in order 0,1,2 on consecutive cycles, and rob_count goes 3→0.
- Fill ROB_DEPTH=8 entries: disp_ready=0 and rob_count=8. Complete the head: commit frees it and disp_ready=1 next cycle; the next tag wraps to 0.
- Dispatch r7 twice (tags 0,1), then commit tag0: RAT[7] stays busy with tag=1. Commit tag1 with a same-cycle new dispatch to r7: RAT[7] stays busy with the new tag.
- flush with 5 entries in flight plus a concurrent CDB: next cycle rob_count=0, all rsN_busy=0, no commit_valid. Async rst_n low mid-run clears state immediately.
